// File: rtl/inst_loader.sv
// Instruction loader: buffers host words in a small FIFO
// and streams them into IRAM as registered write pulses.
module inst_loader #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_start,
  input  logic [8:0]  cmd_base,
  input  logic [8:0]  cmd_count,
  input  logic        inst_valid,
  input  logic [31:0] inst_data,
  output logic        inst_ready,
  output logic        iram_we,
  output logic [8:0]  iram_addr,
  output logic [31:0] iram_wdata,
  output logic        busy,
  output logic        done,
  output logic        err_busy,
  output logic [8:0]  words_written
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [8:0] STEP = 9'(ADDR_STEP);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [8:0]  cnt;
  logic [8:0]  acc_cnt;
  logic [8:0]  cur_addr;
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [31:0] mem [FIFO_DEPTH];

  logic idle_like;
  logic start_ok;
  logic empty;
  logic full;
  logic push;
  logic pop;
  logic last_acc;
  logic drain_done;

  assign idle_like = (state == S_IDLE)
                  || (state == S_DONE);
  assign busy      = (state == S_LOAD)
                  || (state == S_DRAIN);
  assign start_ok  = cmd_start && idle_like;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW])
              && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Ready never looks at inst_valid, nor at a same-cycle pop.
  assign inst_ready = (state == S_LOAD)
                   && !full
                   && (acc_cnt < cnt);

  assign push = inst_valid && inst_ready;
  assign pop  = busy && !empty;

  assign last_acc   = push
                   && ((acc_cnt + 9'd1) == cnt);
  assign drain_done = (state == S_DRAIN)
                   && empty
                   && (words_written == cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (cmd_start) begin
          if (cmd_count != 9'd0) begin
            state_nxt = S_LOAD;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_LOAD: begin
        if (last_acc) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_done) begin
          state_nxt = S_DONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Storage needs no reset: pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= inst_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      acc_cnt       <= '0;
      cur_addr      <= '0;
      words_written <= '0;
      done          <= 1'b0;
      err_busy      <= 1'b0;
    end else if (start_ok) begin
      cnt           <= cmd_count;
      acc_cnt       <= '0;
      cur_addr      <= cmd_base;
      words_written <= '0;
      done          <= (cmd_count == 9'd0);
      err_busy      <= 1'b0;
    end else begin
      if (cmd_start && busy) begin
        err_busy <= 1'b1;
      end
      if (push) begin
        acc_cnt <= acc_cnt + 9'd1;
      end
      if (pop) begin
        cur_addr      <= cur_addr + STEP;
        words_written <= words_written + 9'd1;
      end
      if (drain_done) begin
        done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iram_we    <= 1'b0;
      iram_addr  <= '0;
      iram_wdata <= '0;
    end else begin
      iram_we <= pop;
      if (pop) begin
        iram_addr  <= cur_addr;
        iram_wdata <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Bench for inst_loader: vector table of bursts plus
// hand sequences for zero count, reset and restart.
module tb_inst_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_start = 1'b0;
  logic [8:0]  cmd_base = '0;
  logic [8:0]  cmd_count = '0;
  logic        inst_valid = 1'b0;
  logic [31:0] inst_data = '0;
  logic        inst_ready;
  logic        iram_we;
  logic [8:0]  iram_addr;
  logic [31:0] iram_wdata;
  logic        busy;
  logic        done;
  logic        err_busy;
  logic [8:0]  words_written;

  always #5 clk = ~clk;

  inst_loader #(
    .FIFO_DEPTH(4),
    .ADDR_STEP(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_start(cmd_start),
    .cmd_base(cmd_base),
    .cmd_count(cmd_count),
    .inst_valid(inst_valid),
    .inst_data(inst_data),
    .inst_ready(inst_ready),
    .iram_we(iram_we),
    .iram_addr(iram_addr),
    .iram_wdata(iram_wdata),
    .busy(busy),
    .done(done),
    .err_busy(err_busy),
    .words_written(words_written)
  );

  typedef struct {
    logic [8:0] base;
    logic [8:0] count;
    int extra;
    int mid;
    int gap;
  } vec_t;

  typedef struct {
    logic [8:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t  sb[$];
  int   total = 0;
  int   bad = 0;
  int   wr_seen = 0;
  vec_t vt[6];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (iram_we) begin
      wr_seen++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h want none",
                 iram_addr, iram_wdata);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 64'(iram_addr), 64'(e.addr));
        chk("wr_data", 64'(iram_wdata), 64'(e.data));
      end
    end
  end

  function automatic logic [63:0] outs();
    return 64'({inst_ready, iram_we, iram_addr,
                iram_wdata, busy, done, err_busy,
                words_written});
  endfunction

  task automatic run_burst(input vec_t v, input int vi);
    int acc = 0;
    int cyc = 0;
    int done_cyc = -1;
    bit mid_done = 0;
    logic [8:0] exp_addr = v.base;
    wr_seen = 0;
    @(negedge clk);
    cmd_base  = v.base;
    cmd_count = v.count;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    while (cyc < 300) begin
      cyc++;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      cmd_start = 1'b0;
      if (v.mid >= 0 && acc == v.mid && !mid_done) begin
        cmd_start = 1'b1;
        cmd_base  = 9'h100;
        cmd_count = 9'd2;
        mid_done  = 1;
      end
      inst_valid = (acc < v.count + v.extra)
                && (v.gap == 0 || (cyc % (v.gap + 1)) != 0);
      inst_data = {v.base, 7'(acc), 16'(vi)};
      if (inst_valid && inst_ready) begin
        sb.push_back('{addr: exp_addr, data: inst_data});
        exp_addr += 9'd4;
        acc++;
      end
      @(negedge clk);
    end
    inst_valid = 1'b0;
    cmd_start  = 1'b0;
    chk("done_seen", 64'(done_cyc >= 0), 64'd1);
    if (v.gap == 0) begin
      chk("done_cycle", 64'(done_cyc), 64'(v.count + 3));
    end
    chk("accepted", 64'(acc), 64'(v.count));
    chk("writes", 64'(wr_seen), 64'(v.count));
    chk("words_written", 64'(words_written), 64'(v.count));
    chk("busy_end", 64'(busy), 64'd0);
    chk("ready_end", 64'(inst_ready), 64'd0);
    chk("err_busy", 64'(err_busy), 64'(v.mid >= 0));
    chk("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    vt[0] = '{9'h010, 9'd3, 0, -1, 0};
    vt[1] = '{9'h000, 9'd6, 5, -1, 0};
    vt[2] = '{9'h1F8, 9'd4, 0, -1, 0};
    vt[3] = '{9'h040, 9'd8, 0, 3, 0};
    vt[4] = '{9'h0A0, 9'd9, 0, -1, 2};
    vt[5] = '{9'h1FC, 9'd1, 2, -1, 0};

    #12;
    chk("reset_outs", outs(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero-length burst straight out of reset.
    @(negedge clk);
    cmd_base  = 9'h033;
    cmd_count = 9'd0;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("zero_busy_hold", 64'(busy), 64'd0);
    end
    chk("zero_ww", 64'(words_written), 64'd0);

    for (int i = 0; i < 6; i++) begin
      run_burst(vt[i], i);
    end

    // Reset in the middle of a burst after three writes.
    begin
      int acc = 0;
      logic [8:0] a = 9'h080;
      wr_seen = 0;
      @(negedge clk);
      cmd_base  = 9'h080;
      cmd_count = 9'd8;
      cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      for (int c = 0; c < 50; c++) begin
        #1;
        if (wr_seen >= 3) break;
        inst_valid = 1'b1;
        inst_data  = 32'hBEEF_0000 | 32'(acc);
        if (inst_ready) begin
          sb.push_back('{addr: a, data: inst_data});
          a += 9'd4;
          acc++;
        end
        @(negedge clk);
      end
      chk("rst_pre_writes", 64'(wr_seen), 64'd3);
      rst_n = 1'b0;
      #1;
      chk("rst_outs", outs(), 64'd0);
      sb.delete();
      @(posedge clk);
      #1;
      chk("rst_outs_hold", outs(), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        chk("post_rst_ready", 64'(inst_ready), 64'd0);
        chk("post_rst_we", 64'(iram_we), 64'd0);
      end
      inst_valid = 1'b0;
    end

    run_burst(vt[0], 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: depth of the internal instruction buffer, power of two, minimum 2.
REQ-002 Parameter ADDR_STEP, default 4: IRAM address increment per written word.
REQ-003 clk  input  1  clock; every flop changes state on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cmd_start  input  1  single-cycle request to begin a load burst.
REQ-006 cmd_base  input  9  IRAM start address; sampled when cmd_start is accepted.
REQ-007 cmd_count  input  9  number of words in the burst; sampled when cmd_start is accepted.
REQ-008 inst_valid  input  1  host instruction word valid.
REQ-009 inst_data  input  32  host instruction word.
REQ-010 inst_ready  output  1  block accepts inst_data this cycle.
REQ-011 iram_we  output  1  IRAM write enable; registered.
REQ-012 iram_addr  output  9  IRAM write address; registered.
REQ-013 iram_wdata  output  32  IRAM write data; registered.
REQ-014 busy  output  1  high in LOAD and DRAIN.
REQ-015 done  output  1  sticky; burst complete.
REQ-016 err_busy  output  1  sticky; cmd_start arrived while busy.
REQ-017 words_written  output  9  count of IRAM writes issued in the current burst.

Function
REQ-018 States: IDLE, LOAD, DRAIN, DONE; encoding is free.
REQ-019 cmd_start in IDLE or DONE with cmd_count != 0 shall latch cmd_base and cmd_count, clear done, err_busy and words_written, and enter LOAD on the next edge.
REQ-020 cmd_start in IDLE or DONE with cmd_count == 0 shall enter DONE with done=1 and issue no writes.
REQ-021 cmd_start in LOAD or DRAIN shall be ignored, with err_busy set to 1 on the next edge; the burst in progress continues unaffected.
REQ-022 inst_ready = (state==LOAD) AND FIFO not full AND words accepted < latched count; combinational from state only, never from inst_valid.
REQ-023 A word is accepted when inst_valid and inst_ready are both high at a rising edge; it is pushed into the FIFO at that edge.
REQ-024 Full FIFO: inst_ready=0 even if a pop occurs the same cycle; no overwrite, no data loss.
REQ-025 When the accepted count reaches the latched count, LOAD shall go to DRAIN on that same edge.
REQ-026 In LOAD or DRAIN with FIFO non-empty, one entry is popped per edge. On that edge iram_we<=1, iram_wdata<=entry, iram_addr<=current address, and current address<=(current address+ADDR_STEP) mod 512.
REQ-027 Otherwise iram_we<=0; iram_addr and iram_wdata hold their last values.
REQ-028 Latency: a word accepted at edge N appears with iram_we=1 after edge N+1 when the FIFO was empty. Sustained throughput is 1 word/cycle.
REQ-029 A push and a pop in the same cycle are legal; occupancy is unchanged.
REQ-030 Writes shall leave in acceptance order; current address starts at cmd_base, and 508+4 wraps to 0.
REQ-031 words_written increments on each edge that sets iram_we=1.
REQ-032 DRAIN goes to DONE on the edge after the final pop, when the FIFO is empty and words_written equals the count. DONE sets done=1 and busy=0.
REQ-033 DONE holds until cmd_start; done and err_busy stay asserted in DONE.

Reset
REQ-034 rst_n low shall immediately force IDLE, empty the FIFO, and clear the latched base, count and current address.
REQ-035 Reset values: inst_ready=0, iram_we=0, iram_addr=0, iram_wdata=0, busy=0, done=0, err_busy=0, words_written=0.
REQ-036 Reset during LOAD or DRAIN abandons the burst: buffered words are discarded, and no iram_we pulse follows reset release until a new cmd_start.

Verification
REQ-037 Start base=0x010, count=3, back-to-back words A,B,C -> iram_we pulses at addr 0x010,0x014,0x018 with data A,B,C; done=1 and words_written=3.
REQ-038 Start count=6, IRAM side always writing, host holds valid with 5 extra words queued -> inst_ready drops after the 6th accept; exactly 6 writes; the extra words are not consumed.
REQ-039 Start base=0x1F8, count=4 -> addresses 0x1F8,0x1FC,0x000,0x004.
REQ-040 Start count=0 -> done=1 next cycle, no iram_we, busy never high.
REQ-041 Start count=8, then cmd_start again mid-burst with base=0x100 -> err_busy=1, all 8 writes use the original base, done=1.
REQ-042 Start count=8, rst_n low after 3 writes -> all outputs are at reset values while rst_n is low; no writes after release; a new start then behaves per REQ-037.
